// File: rtl/dcache_nway.sv
// dcache_nway: write-back, write-allocate N-way set-associative data cache
// with true-LRU replacement, plus a halt-time flush that writes every dirty
// block back to memory and then stores the hit count at CNT_ADDR.
//
// Ports:
//   CLK, RST          clock (rising edge), asynchronous active-high reset
//   halt              begin flush; the cache ends in DONE until reset
//   dmemREN/dmemWEN   datapath read/write request (write wins when both are set)
//   dmemaddr          datapath byte address
//   dmemstore         datapath write data
//   dhit              request completes this cycle (held high in DONE)
//   dmemload          read data for the hit word
//   flushed           flush and hit-count store finished
//   dREN/dWEN         memory read/write strobe
//   daddr/dstore      memory word address / write data
//   dload             memory read data
//   dwait             memory busy; a transfer completes in a cycle with dwait=0
module dcache_nway #(
    parameter int unsigned SETS     = 8,
    parameter int unsigned WAYS     = 2,
    parameter int unsigned WORDS    = 2,
    parameter logic [31:0] CNT_ADDR = 32'h0000_3100
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        halt,
    input  logic        dmemREN,
    input  logic        dmemWEN,
    input  logic [31:0] dmemaddr,
    input  logic [31:0] dmemstore,
    output logic        dhit,
    output logic [31:0] dmemload,
    output logic        flushed,
    output logic        dREN,
    output logic        dWEN,
    output logic [31:0] daddr,
    output logic [31:0] dstore,
    input  logic [31:0] dload,
    input  logic        dwait
);
    localparam int unsigned WOFF = $clog2(WORDS);
    localparam int unsigned IDXW = $clog2(SETS);
    localparam int unsigned TAGW = 30 - WOFF - IDXW;
    localparam int unsigned WW   = (WOFF > 0) ? WOFF : 1;
    localparam int unsigned AW   = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [2:0] {
        IDLE, WB, FILL, FLUSH_SCAN, FLUSH_WB, CNT, DONE
    } state_t;

    state_t state_q, state_n;

    // Cache arrays; ages form a permutation per set (0 = most recently hit).
    logic            valid_q [SETS][WAYS];
    logic            dirty_q [SETS][WAYS];
    logic [AW-1:0]   age_q   [SETS][WAYS];
    logic [TAGW-1:0] tag_q   [SETS][WAYS];
    logic [31:0]     data_q  [SETS][WAYS][WORDS];

    // Miss context latched on the miss cycle, transfer and flush pointers.
    logic [AW-1:0]   vic_q;
    logic [IDXW-1:0] lidx_q;
    logic [TAGW-1:0] ltag_q;
    logic [WW-1:0]   wcnt_q;
    logic [IDXW-1:0] fset_q;
    logic [AW-1:0]   fway_q;
    logic [31:0]     hits_q;

    // Request address split.
    logic [TAGW-1:0] req_tag;
    logic [IDXW-1:0] req_idx;
    logic [WW-1:0]   req_word;
    logic            unused_byte_off;

    assign req_tag         = dmemaddr[31 -: TAGW];
    assign req_idx         = dmemaddr[2 + WOFF +: IDXW];
    assign req_word        = WW'((dmemaddr >> 2) & 32'(WORDS - 1));
    assign unused_byte_off = ^dmemaddr[1:0];

    logic last_word, last_pair;
    assign last_word = (wcnt_q == WW'(WORDS - 1));
    assign last_pair = (fset_q == IDXW'(SETS - 1)) && (fway_q == AW'(WAYS - 1));

    function automatic logic [31:0] blk_addr(input logic [TAGW-1:0] tag,
                                             input logic [IDXW-1:0] idx,
                                             input logic [WW-1:0]   word);
        blk_addr = (32'({tag, idx}) << (WOFF + 2)) | (32'(word) << 2);
    endfunction

    // Tag lookup and victim choice for the current request's set.
    logic          hit_c, inv_found;
    logic [AW-1:0] hit_way, vic_c;

    always_comb begin
        hit_c     = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        vic_c     = '0;
        for (int w = 0; w < int'(WAYS); w++) begin
            if (valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag)) begin
                hit_c   = 1'b1;
                hit_way = AW'(w);
            end
        end
        for (int w = 0; w < int'(WAYS); w++) begin
            if (age_q[req_idx][w] == AW'(WAYS - 1)) vic_c = AW'(w);
        end
        // Any invalid way takes precedence over the oldest one; lowest wins.
        for (int w = 0; w < int'(WAYS); w++) begin
            if (!valid_q[req_idx][w] && !inv_found) begin
                inv_found = 1'b1;
                vic_c     = AW'(w);
            end
        end
    end

    // Next-state and output decode.
    logic hit_take_c, miss_c;

    always_comb begin
        state_n    = state_q;
        dhit       = 1'b0;
        dmemload   = '0;
        flushed    = 1'b0;
        dREN       = 1'b0;
        dWEN       = 1'b0;
        daddr      = '0;
        dstore     = '0;
        hit_take_c = 1'b0;
        miss_c     = 1'b0;
        case (state_q)
            IDLE: begin
                if (halt) begin
                    state_n = FLUSH_SCAN;
                end else if (dmemWEN || dmemREN) begin
                    if (hit_c) begin
                        dhit       = 1'b1;
                        dmemload   = data_q[req_idx][hit_way][req_word];
                        hit_take_c = 1'b1;
                    end else begin
                        miss_c  = 1'b1;
                        state_n = (valid_q[req_idx][vic_c] && dirty_q[req_idx][vic_c])
                                  ? WB : FILL;
                    end
                end
            end
            WB: begin
                dWEN   = 1'b1;
                daddr  = blk_addr(tag_q[lidx_q][vic_q], lidx_q, wcnt_q);
                dstore = data_q[lidx_q][vic_q][wcnt_q];
                if (!dwait && last_word) state_n = FILL;
            end
            FILL: begin
                dREN  = 1'b1;
                daddr = blk_addr(ltag_q, lidx_q, wcnt_q);
                if (!dwait && last_word) state_n = IDLE;
            end
            FLUSH_SCAN: begin
                if (valid_q[fset_q][fway_q] && dirty_q[fset_q][fway_q]) state_n = FLUSH_WB;
                else if (last_pair)                                   state_n = CNT;
            end
            FLUSH_WB: begin
                dWEN   = 1'b1;
                daddr  = blk_addr(tag_q[fset_q][fway_q], fset_q, wcnt_q);
                dstore = data_q[fset_q][fway_q][wcnt_q];
                if (!dwait && last_word) state_n = last_pair ? CNT : FLUSH_SCAN;
            end
            CNT: begin
                dWEN   = 1'b1;
                daddr  = CNT_ADDR;
                dstore = hits_q;
                if (!dwait) state_n = DONE;
            end
            DONE: begin
                flushed = 1'b1;
                dhit    = 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state_q <= IDLE;
        else     state_q <= state_n;
    end

    // Control state, valid/dirty/age bookkeeping and the hit counter.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            vic_q  <= '0;
            lidx_q <= '0;
            ltag_q <= '0;
            wcnt_q <= '0;
            fset_q <= '0;
            fway_q <= '0;
            hits_q <= '0;
            for (int s = 0; s < int'(SETS); s++) begin
                for (int w = 0; w < int'(WAYS); w++) begin
                    valid_q[s][w] <= 1'b0;
                    dirty_q[s][w] <= 1'b0;
                    age_q[s][w]   <= AW'(w);
                end
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (halt) begin
                        fset_q <= '0;
                        fway_q <= '0;
                        wcnt_q <= '0;
                    end
                    if (hit_take_c) begin
                        hits_q <= hits_q + 32'd1;
                        if (dmemWEN) dirty_q[req_idx][hit_way] <= 1'b1;
                        // Hit way becomes youngest; only ways younger than it age.
                        for (int w = 0; w < int'(WAYS); w++) begin
                            if (AW'(w) == hit_way)
                                age_q[req_idx][w] <= '0;
                            else if (age_q[req_idx][w] < age_q[req_idx][hit_way])
                                age_q[req_idx][w] <= age_q[req_idx][w] + AW'(1);
                        end
                    end
                    if (miss_c) begin
                        vic_q  <= vic_c;
                        lidx_q <= req_idx;
                        ltag_q <= req_tag;
                        wcnt_q <= '0;
                    end
                end
                WB: begin
                    if (!dwait) wcnt_q <= last_word ? '0 : wcnt_q + WW'(1);
                end
                FILL: begin
                    if (!dwait) begin
                        wcnt_q <= last_word ? '0 : wcnt_q + WW'(1);
                        if (last_word) begin
                            valid_q[lidx_q][vic_q] <= 1'b1;
                            dirty_q[lidx_q][vic_q] <= 1'b0;
                        end
                    end
                end
                FLUSH_SCAN: begin
                    wcnt_q <= '0;
                    if (!(valid_q[fset_q][fway_q] && dirty_q[fset_q][fway_q]) && !last_pair) begin
                        if (fway_q == AW'(WAYS - 1)) begin
                            fway_q <= '0;
                            fset_q <= fset_q + IDXW'(1);
                        end else begin
                            fway_q <= fway_q + AW'(1);
                        end
                    end
                end
                FLUSH_WB: begin
                    if (!dwait) begin
                        wcnt_q <= last_word ? '0 : wcnt_q + WW'(1);
                        if (last_word) begin
                            dirty_q[fset_q][fway_q] <= 1'b0;
                            if (!last_pair) begin
                                if (fway_q == AW'(WAYS - 1)) begin
                                    fway_q <= '0;
                                    fset_q <= fset_q + IDXW'(1);
                                end else begin
                                    fway_q <= fway_q + AW'(1);
                                end
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Tag and data arrays; contents are qualified by valid, so no reset.
    always_ff @(posedge CLK) begin
        if (hit_take_c && dmemWEN) data_q[req_idx][hit_way][req_word] <= dmemstore;
        if ((state_q == FILL) && !dwait) begin
            data_q[lidx_q][vic_q][wcnt_q] <= dload;
            if (last_word) tag_q[lidx_q][vic_q] <= ltag_q;
        end
    end

endmodule

// File: tb/tb_dcache_nway.sv
// tb_dcache_nway: directed + random requests against dcache_nway, checked
// against a recency-list cache model and a flat memory image.
module tb_dcache_nway;
    localparam int unsigned SETS     = 8;
    localparam int unsigned WAYS     = 2;
    localparam int unsigned WORDS    = 2;
    localparam logic [31:0] CNT_ADDR = 32'h0000_3100;
    localparam int unsigned MEMW     = 4096;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } xfer_t;

    logic        CLK = 1'b0;
    logic        RST, halt, dmemREN, dmemWEN;
    logic [31:0] dmemaddr, dmemstore;
    logic        dhit, flushed, dREN, dWEN;
    logic [31:0] dmemload, daddr, dstore, dload;
    logic        dwait = 1'b0;

    logic [31:0] mem    [MEMW];
    logic [31:0] shadow [MEMW];
    xfer_t       act_q [$];

    int stall_n = 0;
    int wcount = 0;
    int stab_err = 0;
    int proto_err = 0;
    bit held_v = 1'b0;
    logic [65:0] held;

    int total = 0;
    int bad = 0;

    // Reference model: per set, valid tags ordered most- to least-recent.
    int mcnt   [SETS];
    int mtag   [SETS][WAYS];
    bit mdirty [SETS][WAYS];
    int nreq;

    assign dload = mem[daddr[13:2]];

    dcache_nway #(.SETS(SETS), .WAYS(WAYS), .WORDS(WORDS), .CNT_ADDR(CNT_ADDR)) dut (
        .CLK(CLK), .RST(RST), .halt(halt), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
        .dmemaddr(dmemaddr), .dmemstore(dmemstore), .dhit(dhit), .dmemload(dmemload),
        .flushed(flushed), .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dload(dload), .dwait(dwait)
    );

    always #5 CLK = ~CLK;

    // Memory: stalls each transfer stall_n cycles, logs completed transfers.
    always @(negedge CLK) begin
        if (RST) begin
            dwait  = 1'b0;
            wcount = 0;
            held_v = 1'b0;
        end else begin
            if (dREN && dWEN) proto_err++;
            if (!dREN && !dWEN && (daddr != 32'd0 || dstore != 32'd0)) proto_err++;
            if (held_v && (held !== {dREN, dWEN, daddr, dstore})) stab_err++;
            held_v = 1'b0;
            if (dREN || dWEN) begin
                if (wcount < stall_n) begin
                    dwait  = 1'b1;
                    wcount++;
                    held_v = 1'b1;
                    held   = {dREN, dWEN, daddr, dstore};
                end else begin
                    dwait  = 1'b0;
                    wcount = 0;
                    act_q.push_back('{dWEN, daddr, dWEN ? dstore : dload});
                    if (dWEN) mem[daddr[13:2]] = dstore;
                end
            end else begin
                dwait  = 1'b0;
                wcount = 0;
            end
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < int'(SETS); s++) mcnt[s] = 0;
        for (int i = 0; i < int'(MEMW); i++) shadow[i] = mem[i];
        nreq = 0;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1; halt = 1'b0; dmemREN = 1'b0; dmemWEN = 1'b0;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        model_reset();
    endtask

    task automatic do_req(input bit we, input logic [31:0] addr, input logic [31:0] wd);
        int blk, set, tg, pos, cyc, exp_lat, wa, t;
        bit got, d;
        logic [31:0] rd, exp_rd;
        xfer_t exq [$];
        blk = int'(addr) / int'(4 * WORDS);
        set = blk % int'(SETS);
        tg  = blk / int'(SETS);
        pos = -1;
        for (int i = 0; i < mcnt[set]; i++) if (mtag[set][i] == tg) pos = i;
        if (pos < 0) begin
            if (mcnt[set] == int'(WAYS)) begin
                pos = int'(WAYS) - 1;
                if (mdirty[set][pos])
                    for (int w = 0; w < int'(WORDS); w++) begin
                        wa = (mtag[set][pos] * int'(SETS) + set) * int'(WORDS) * 4 + 4 * w;
                        exq.push_back('{1'b1, 32'(wa), shadow[wa / 4]});
                    end
            end else begin
                pos = mcnt[set];
                mcnt[set]++;
            end
            for (int w = 0; w < int'(WORDS); w++) begin
                wa = (tg * int'(SETS) + set) * int'(WORDS) * 4 + 4 * w;
                exq.push_back('{1'b0, 32'(wa), shadow[wa / 4]});
            end
            mtag[set][pos]   = tg;
            mdirty[set][pos] = 1'b0;
        end
        t = mtag[set][pos];
        d = mdirty[set][pos];
        for (int i = pos; i > 0; i--) begin
            mtag[set][i]   = mtag[set][i - 1];
            mdirty[set][i] = mdirty[set][i - 1];
        end
        mtag[set][0]   = t;
        mdirty[set][0] = d | we;
        exp_lat = (exq.size() == 0) ? 0 : exq.size() * (stall_n + 1) + 1;
        exp_rd  = shadow[addr[13:2]];
        if (we) shadow[addr[13:2]] = wd;
        nreq++;

        act_q.delete();
        @(posedge CLK); #1;
        dmemREN = !we; dmemWEN = we; dmemaddr = addr; dmemstore = wd;
        cyc = 0; got = 1'b0; rd = '0;
        while (!got && cyc < 400) begin
            @(negedge CLK);
            cyc++;
            if (dhit) begin
                got = 1'b1;
                rd  = dmemload;
            end
        end
        @(posedge CLK); #1;
        dmemREN = 1'b0; dmemWEN = 1'b0;
        chk("req_done", 128'(got), 128'(1));
        chk("latency", 128'(cyc - 1), 128'(exp_lat));
        if (!we) chk("rdata", 128'(rd), 128'(exp_rd));
        chk("xfer_count", 128'(act_q.size()), 128'(exq.size()));
        for (int i = 0; i < exq.size() && i < act_q.size(); i++)
            chk("xfer", 128'(act_q[i]), 128'(exq[i]));
    endtask

    task automatic do_halt();
        int nd, cyc, wmatch, nm, n;
        bit got;
        bit expaddr [int];
        nd = 0;
        for (int s = 0; s < int'(SETS); s++)
            for (int i = 0; i < mcnt[s]; i++)
                if (mdirty[s][i]) begin
                    nd++;
                    for (int w = 0; w < int'(WORDS); w++)
                        expaddr[(mtag[s][i] * int'(SETS) + s) * int'(WORDS) * 4 + 4 * w] = 1'b1;
                end
        act_q.delete();
        @(posedge CLK); #1;
        halt = 1'b1;
        cyc = 0; got = 1'b0;
        while (!got && cyc < 3000) begin
            @(negedge CLK);
            cyc++;
            if (flushed) got = 1'b1;
        end
        chk("flush_done", 128'(got), 128'(1));
        chk("done_outputs", 128'({dhit, flushed, dREN, dWEN}), 128'(4'b1100));
        n = act_q.size();
        chk("flush_xfers", 128'(n), 128'(nd * int'(WORDS) + 1));
        wmatch = 0;
        for (int i = 0; i < n - 1; i++)
            if (act_q[i].we && expaddr.exists(int'(act_q[i].addr))
                && act_q[i].data === shadow[act_q[i].addr[13:2]]) wmatch++;
        chk("flush_blocks", 128'(wmatch), 128'(nd * int'(WORDS)));
        if (n > 0) chk("count_store", 128'(act_q[n - 1]), 128'({1'b1, CNT_ADDR, 32'(nreq)}));
        nm = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== shadow[i]) nm++;
        chk("mem_image", 128'(nm), 128'(0));
        halt = 1'b0; dmemREN = 1'b1; dmemaddr = 32'h0000_0300;
        @(negedge CLK);
        @(negedge CLK);
        chk("done_holds", 128'({dhit, flushed, dREN, dWEN}), 128'(4'b1100));
        dmemREN = 1'b0;
    endtask

    task automatic run_directed();
        do_req(1'b0, 32'h0000_0040, 32'h0);
        do_req(1'b0, 32'h0000_0040, 32'h0);
        do_req(1'b1, 32'h0000_0044, 32'h1234_5678);
        do_req(1'b0, 32'h0000_0044, 32'h0);
        do_req(1'b0, 32'h0000_0080, 32'h0);
        do_req(1'b0, 32'h0000_00C0, 32'h0);
        do_req(1'b0, 32'h0000_0140, 32'h0);
        do_req(1'b0, 32'h0000_00C4, 32'h0);
        do_req(1'b0, 32'h0000_0080, 32'h0);
        do_req(1'b0, 32'h0000_0044, 32'h0);
    endtask

    task automatic run_random(input int n);
        for (int i = 0; i < n; i++)
            do_req($urandom_range(0, 2) == 0, 32'($urandom_range(0, 255) * 4), $urandom);
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cyc;
        bit found;
        RST = 1'b1; halt = 1'b0; dmemREN = 1'b0; dmemWEN = 1'b0;
        dmemaddr = '0; dmemstore = '0;
        for (int i = 0; i < int'(MEMW); i++) mem[i] = $urandom;
        mem[32'h40 >> 2] = 32'hAAAA_0001;
        model_reset();
        repeat (3) @(negedge CLK);
        chk("reset_outputs", 128'({dhit, flushed, dREN, dWEN, daddr, dstore, dmemload}), 128'(0));
        RST = 1'b0;

        // Zero-wait memory: directed, random, then a full flush.
        run_directed();
        run_random(150);
        do_halt();

        // Exact hit count with one dirty block.
        do_reset();
        do_req(1'b0, 32'h0000_0040, 32'h0);
        do_req(1'b1, 32'h0000_0044, 32'hCAFE_0044);
        do_req(1'b0, 32'h0000_0044, 32'h0);
        do_req(1'b0, 32'h0000_0040, 32'h0);
        do_req(1'b0, 32'h0000_0044, 32'h0);
        do_halt();

        // Stalled memory: three busy cycles per transfer.
        do_reset();
        stall_n = 3;
        run_directed();
        run_random(40);
        do_halt();
        stall_n = 0;

        // Reset in the middle of a fill.
        do_reset();
        act_q.delete();
        @(posedge CLK); #1;
        dmemREN = 1'b1; dmemaddr = 32'h0000_0200;
        found = 1'b0; cyc = 0;
        while (!found && cyc < 100) begin
            @(negedge CLK);
            cyc++;
            if (dREN && daddr == 32'h0000_0204) found = 1'b1;
        end
        chk("fill_word1_seen", 128'(found), 128'(1));
        #1 RST = 1'b1;
        #1;
        chk("async_reset_outputs", 128'({dhit, flushed, dREN, dWEN, daddr, dstore, dmemload}), 128'(0));
        dmemREN = 1'b0;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        model_reset();
        do_req(1'b0, 32'h0000_0200, 32'h0);
        do_req(1'b0, 32'h0000_0204, 32'h0);

        chk("stall_stability", 128'(stab_err), 128'(0));
        chk("bus_protocol", 128'(proto_err), 128'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dcache_nway.md
DCACHE_NWAY -- requirements
Module: dcache_nway

Interface
REQ-001 Parameter SETS, default 8: number of sets; power of two, 2..256.
REQ-002 Parameter WAYS, default 2: associativity; one of 1, 2, 4.
REQ-003 Parameter WORDS, default 2: 32-bit words per block; one of 1, 2, 4, 8.
REQ-004 Parameter CNT_ADDR, default 32'h0000_3100: byte address where the hit count is stored at halt.
REQ-005 The block SHALL have these ports (clock and reset first):
- CLK  in  1  sole clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- halt  in  1  datapath halt; start flush.
- dmemREN  in  1  datapath read request.
- dmemWEN  in  1  datapath write request.
- dmemaddr  in  32  datapath byte address.
- dmemstore  in  32  write data.
- dhit  out  1  request complete this cycle.
- dmemload  out  32  read data, valid when dhit=1 and dmemREN=1.
- flushed  out  1  flush and count store complete.
- dREN  out  1  memory read.
- dWEN  out  1  memory write.
- daddr  out  32  memory word address, bits [1:0]=0.
- dstore  out  32  memory write data.
- dload  in  32  memory read data.
- dwait  in  1  memory busy; a transfer completes in the cycle dwait=0.

Function
REQ-006 Address split SHALL be: [1:0] byte offset (ignored), then log2(WORDS) word offset, then log2(SETS) index, with the remaining upper bits as tag.
REQ-007 Each way SHALL hold valid, dirty, tag, WORDS data words; each set SHALL hold a log2(WAYS)-bit age per way (true LRU; 0 = most recent).
REQ-008 FSM states: IDLE, WB, FILL, FLUSH_SCAN, FLUSH_WB, CNT, DONE.
REQ-009 IDLE priority: halt over dmemWEN over dmemREN; halt -> FLUSH_SCAN with set=0, way=0.
REQ-010 IDLE hit (valid and tag match in any way): dhit=1 combinationally in the same cycle, dmemload=matching word; write hit updates the word and sets dirty at the next edge; zero miss penalty.
REQ-011 On each hit, the hit way's age SHALL become 0, ways younger than its old age SHALL increment, and the others SHALL hold.
REQ-012 Miss victim: lowest-numbered invalid way; if none, the way with age WAYS-1. The victim is latched on the miss cycle, and dhit=0.
REQ-013 Miss with valid dirty victim -> WB; otherwise -> FILL.
REQ-014 WB: dWEN=1, daddr={victim tag, index, word counter, 2'b00}, dstore=victim word; word counter advances when dwait=0; after word WORDS-1 -> FILL with counter=0.
REQ-015 FILL: dREN=1, daddr={request tag, index, word counter, 2'b00}; dload is written into the victim when dwait=0; after word WORDS-1 the victim is set valid=1, dirty=0, tag=request tag, and the FSM returns to IDLE.
REQ-016 The retried request then hits in IDLE (REQ-010); miss latency = (WB ? WORDS : 0) + WORDS memory transfers + 1 cycle.
REQ-017 dREN and dWEN SHALL never both be 1; outside WB/FILL/FLUSH_WB/CNT both SHALL be 0, and daddr and dstore SHALL be 0.
REQ-018 FLUSH_SCAN checks one (set, way) per cycle in set-major order: valid and dirty -> FLUSH_WB; otherwise advance; after the last pair -> CNT.
REQ-019 FLUSH_WB writes WORDS words as in WB using the scanned tag and set, clears dirty, then returns to FLUSH_SCAN at the next pair (or CNT after the last pair).
REQ-020 CNT: dWEN=1, daddr=CNT_ADDR, dstore=hit count; when dwait=0 -> DONE.
REQ-021 DONE is terminal until reset: flushed=1, dhit=1, no memory traffic, halt/REN/WEN ignored.
REQ-022 Hit counter: 32-bit, increments by 1 on each IDLE hit cycle (read or write), wraps at 2^32, frozen from halt onward.
REQ-023 dmemREN/dmemWEN changes during WB/FILL SHALL be ignored; the address is latched at the miss.

Reset
REQ-024 RST=1 SHALL immediately and asynchronously force: state IDLE, all valid and dirty bits 0, ages set to way number, word counter, flush pointers and hit counter 0, and all outputs 0 (dmemload=0).
REQ-025 Reset during WB, FILL or flush SHALL abort the transfer with no partial state retained.
REQ-026 Data and tag arrays need not be reset.

Verification (defaults SETS=8, WAYS=2, WORDS=2)
REQ-027 Read 0x0000_0040, memory word 0x40=0xAAAA_0001, dwait=0 -> dREN at 0x40 then 0x44, then dhit=1 with dmemload=0xAAAA_0001 on the 3rd cycle; a re-read hits in 1 cycle.
REQ-028 Write 0x0000_0044 with data 0x1234_5678 after the fill -> dhit same cycle; a read of 0x44 returns 0x1234_5678; no memory write.
REQ-029 Dirty 0x40, fill 0x80, then access 0xC0 (same set) -> WB of 0x40/0x44 (dstore=0x1234_5678 at 0x44) precedes FILL of 0xC0/0xC4; the 0x80 way is retained.
REQ-030 After 5 hits, halt with one dirty block -> two dWEN writes of that block, then dWEN at 0x3100 with dstore=5, then flushed=1.
REQ-031 dwait held 1 for 3 cycles on every transfer -> outputs stable while stalled; results identical to the dwait=0 run.
REQ-032 Assert RST during FILL word 1 -> all outputs 0 immediately; after release, a read of the same address misses again.
